// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between
// instruction fetch (read only) and the memory stage (read/write).
module sdram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_fin,
    output logic [DATA_W-1:0]   if_data,
    input  logic                mem_rd_req,
    input  logic                mem_wr_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_fin,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                sdram_rd_req,
    output logic [ADDR_W-1:0]   sdram_rd_addr,
    input  logic                sdram_rd_fin,
    input  logic [DATA_W-1:0]   sdram_rd_data,
    output logic                sdram_wr_req,
    output logic [ADDR_W-1:0]   sdram_wr_addr,
    output logic [DATA_W-1:0]   sdram_wr_data,
    output logic [DATA_W/8-1:0] sdram_wr_mask,
    input  logic                sdram_wr_fin,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_MEM_WR,
        S_DONE
    } state_t;

    state_t              r_state,    w_state;
    logic                r_last_mem, w_last_mem;
    logic                r_rd_req,   w_rd_req;
    logic                r_wr_req,   w_wr_req;
    logic                r_if_fin,   w_if_fin;
    logic                r_mem_fin,  w_mem_fin;
    logic [ADDR_W-1:0]   r_rd_addr,  w_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr,  w_wr_addr;
    logic [DATA_W-1:0]   r_wr_data,  w_wr_data;
    logic [MASK_W-1:0]   r_wr_mask,  w_wr_mask;
    logic [DATA_W-1:0]   r_if_data,  w_if_data;
    logic [DATA_W-1:0]   r_mem_data, w_mem_data;
    logic                w_mem_req;
    logic                w_grant_mem;

    // On a tie the requester that did not own the last grant wins
    assign w_mem_req   = mem_rd_req | mem_wr_req;
    assign w_grant_mem = w_mem_req & (~if_req | ~r_last_mem);

    always_comb begin
        w_state    = r_state;
        w_last_mem = r_last_mem;
        w_rd_req   = r_rd_req;
        w_wr_req   = r_wr_req;
        w_if_fin   = 1'b0;
        w_mem_fin  = 1'b0;
        w_rd_addr  = r_rd_addr;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;
        w_wr_mask  = r_wr_mask;
        w_if_data  = r_if_data;
        w_mem_data = r_mem_data;
        case (r_state)
            S_IDLE: begin
                if (w_grant_mem) begin
                    w_last_mem = 1'b1;
                    if (mem_wr_req) begin
                        w_wr_req  = 1'b1;
                        w_wr_addr = mem_addr;
                        w_wr_data = mem_wdata;
                        w_wr_mask = mem_wmask;
                        w_state   = S_MEM_WR;
                    end else begin
                        w_rd_req  = 1'b1;
                        w_rd_addr = mem_addr;
                        w_state   = S_MEM_RD;
                    end
                end else if (if_req) begin
                    w_last_mem = 1'b0;
                    w_rd_req   = 1'b1;
                    w_rd_addr  = if_addr;
                    w_state    = S_IF_RD;
                end
            end
            S_IF_RD: begin
                if (sdram_rd_fin) begin
                    w_rd_req  = 1'b0;
                    w_if_data = sdram_rd_data;
                    w_if_fin  = 1'b1;
                    w_state   = S_DONE;
                end
            end
            S_MEM_RD: begin
                if (sdram_rd_fin) begin
                    w_rd_req   = 1'b0;
                    w_mem_data = sdram_rd_data;
                    w_mem_fin  = 1'b1;
                    w_state    = S_DONE;
                end
            end
            S_MEM_WR: begin
                if (sdram_wr_fin) begin
                    w_wr_req  = 1'b0;
                    w_mem_fin = 1'b1;
                    w_state   = S_DONE;
                end
            end
            // Requests ignored here so a requester can drop req after fin
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_mem <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_if_fin   <= 1'b0;
            r_mem_fin  <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_mask  <= '0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state;
            r_last_mem <= w_last_mem;
            r_rd_req   <= w_rd_req;
            r_wr_req   <= w_wr_req;
            r_if_fin   <= w_if_fin;
            r_mem_fin  <= w_mem_fin;
            r_rd_addr  <= w_rd_addr;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_wr_mask  <= w_wr_mask;
            r_if_data  <= w_if_data;
            r_mem_data <= w_mem_data;
        end
    end

    assign if_fin        = r_if_fin;
    assign if_data       = r_if_data;
    assign mem_fin       = r_mem_fin;
    assign mem_rdata     = r_mem_data;
    assign sdram_rd_req  = r_rd_req;
    assign sdram_rd_addr = r_rd_addr;
    assign sdram_wr_req  = r_wr_req;
    assign sdram_wr_addr = r_wr_addr;
    assign sdram_wr_data = r_wr_data;
    assign sdram_wr_mask = r_wr_mask;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: drives and samples just after the
// rising edge, the design updates on the falling edge.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_fin;
    logic [31:0] if_data;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_fin;
    logic [31:0] mem_rdata;
    logic        sdram_rd_req;
    logic [31:0] sdram_rd_addr;
    logic        sdram_rd_fin;
    logic [31:0] sdram_rd_data;
    logic        sdram_wr_req;
    logic [31:0] sdram_wr_addr;
    logic [31:0] sdram_wr_data;
    logic [3:0]  sdram_wr_mask;
    logic        sdram_wr_fin;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    sdram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_fin        (if_fin),
        .if_data       (if_data),
        .mem_rd_req    (mem_rd_req),
        .mem_wr_req    (mem_wr_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_fin       (mem_fin),
        .mem_rdata     (mem_rdata),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_rd_addr (sdram_rd_addr),
        .sdram_rd_fin  (sdram_rd_fin),
        .sdram_rd_data (sdram_rd_data),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_wr_data (sdram_wr_data),
        .sdram_wr_mask (sdram_wr_mask),
        .sdram_wr_fin  (sdram_wr_fin),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0;
        mem_rd_req = 0; mem_wr_req = 0;
        mem_addr = 0; mem_wdata = 0; mem_wmask = 0;
        sdram_rd_fin = 0; sdram_rd_data = 0; sdram_wr_fin = 0;
        tick();
        do_reset();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_rdreq",  32'(sdram_rd_req), 32'd0);
        chk("rst_wrreq",  32'(sdram_wr_req), 32'd0);
        chk("rst_fins",   32'({if_fin, mem_fin}), 32'd0);
        chk("rst_rdaddr", sdram_rd_addr, 32'd0);
        chk("rst_ifdata", if_data, 32'd0);

        // Tie right after reset: MEM first, then IF, then MEM
        if_req = 1; if_addr = 32'h40;
        mem_rd_req = 1; mem_addr = 32'h80;
        tick();
        chk("tie1_rdreq", 32'(sdram_rd_req), 32'd1);
        chk("tie1_addr",  sdram_rd_addr, 32'h80);
        sdram_rd_fin = 1; sdram_rd_data = 32'hAAAA0001;
        tick();
        sdram_rd_fin = 0;
        chk("tie1_memfin", 32'(mem_fin), 32'd1);
        chk("tie1_ifnofin", 32'(if_fin), 32'd0);
        chk("tie1_rdata", mem_rdata, 32'hAAAA0001);
        chk("tie1_ifdata", if_data, 32'd0);
        tick();
        chk("tie1_done_busy", 32'(busy), 32'd0);
        chk("tie1_done_rdreq", 32'(sdram_rd_req), 32'd0);
        tick();
        chk("tie2_addr", sdram_rd_addr, 32'h40);
        chk("tie2_rdreq", 32'(sdram_rd_req), 32'd1);
        sdram_rd_fin = 1; sdram_rd_data = 32'h11110002;
        tick();
        sdram_rd_fin = 0;
        chk("tie2_iffin", 32'(if_fin), 32'd1);
        chk("tie2_memnofin", 32'(mem_fin), 32'd0);
        chk("tie2_ifdata", if_data, 32'h11110002);
        tick();
        tick();
        chk("tie3_addr", sdram_rd_addr, 32'h80);
        sdram_rd_fin = 1; sdram_rd_data = 32'h33;
        tick();
        sdram_rd_fin = 0;
        if_req = 0; mem_rd_req = 0;
        chk("tie3_memfin", 32'(mem_fin), 32'd1);
        tick();
        chk("tie3_finclr", 32'(mem_fin), 32'd0);

        // Fetch only, controller answers after 3 cycles
        if_req = 1; if_addr = 32'h100;
        tick();
        chk("f_rdreq", 32'(sdram_rd_req), 32'd1);
        chk("f_addr",  sdram_rd_addr, 32'h100);
        chk("f_busy",  32'(busy), 32'd1);
        tick();
        tick();
        chk("f_hold", 32'(sdram_rd_req), 32'd1);
        chk("f_nofin", 32'(if_fin), 32'd0);
        sdram_rd_fin = 1; sdram_rd_data = 32'hDEADBEEF;
        tick();
        sdram_rd_fin = 0; if_req = 0;
        chk("f_fin",    32'(if_fin), 32'd1);
        chk("f_data",   if_data, 32'hDEADBEEF);
        chk("f_rddrop", 32'(sdram_rd_req), 32'd0);
        chk("f_dbusy",  32'(busy), 32'd1);
        tick();
        chk("f_fin1", 32'(if_fin), 32'd0);
        chk("f_idle", 32'(busy), 32'd0);
        chk("f_keep", if_data, 32'hDEADBEEF);

        // Write with inputs changing during the grant, plus stray rd fin
        mem_wr_req = 1; mem_addr = 32'h2000;
        mem_wdata = 32'h12345678; mem_wmask = 4'b0011;
        tick();
        chk("w_wrreq", 32'(sdram_wr_req), 32'd1);
        chk("w_rdreq", 32'(sdram_rd_req), 32'd0);
        mem_wdata = 32'hFFFFFFFF; mem_wmask = 4'hF; mem_addr = 32'h0;
        tick();
        chk("w_data", sdram_wr_data, 32'h12345678);
        chk("w_mask", 32'(sdram_wr_mask), 32'h3);
        chk("w_addr", sdram_wr_addr, 32'h2000);
        sdram_rd_fin = 1;
        tick();
        sdram_rd_fin = 0;
        chk("w_stray", 32'(mem_fin), 32'd0);
        chk("w_hold", 32'(sdram_wr_req), 32'd1);
        sdram_wr_fin = 1;
        tick();
        sdram_wr_fin = 0; mem_wr_req = 0;
        chk("w_fin", 32'(mem_fin), 32'd1);
        chk("w_drop", 32'(sdram_wr_req), 32'd0);
        tick();
        chk("w_fin1", 32'(mem_fin), 32'd0);
        chk("w_idle", 32'(busy), 32'd0);

        // Illegal rd+wr: write wins
        mem_rd_req = 1; mem_wr_req = 1;
        mem_addr = 32'h3000; mem_wdata = 32'h55; mem_wmask = 4'hF;
        tick();
        chk("ill_wr", 32'(sdram_wr_req), 32'd1);
        chk("ill_rd", 32'(sdram_rd_req), 32'd0);
        chk("ill_addr", sdram_wr_addr, 32'h3000);
        sdram_wr_fin = 1;
        tick();
        sdram_wr_fin = 0; mem_rd_req = 0; mem_wr_req = 0;
        chk("ill_fin", 32'(mem_fin), 32'd1);
        tick();

        // Reset in IF_RD, late fin afterwards
        if_req = 1; if_addr = 32'h500;
        tick();
        chk("rr_rdreq", 32'(sdram_rd_req), 32'd1);
        reset = 1;
        tick();
        reset = 0; if_req = 0;
        chk("rr_rdreq0", 32'(sdram_rd_req), 32'd0);
        chk("rr_busy",   32'(busy), 32'd0);
        chk("rr_addr",   sdram_rd_addr, 32'd0);
        chk("rr_ifdata", if_data, 32'd0);
        chk("rr_wrdata", sdram_wr_data, 32'd0);
        sdram_rd_fin = 1; sdram_rd_data = 32'h999;
        tick();
        sdram_rd_fin = 0;
        chk("rr_nofin", 32'(if_fin), 32'd0);
        chk("rr_idle",  32'(busy), 32'd0);

        // Stray fins while idle
        sdram_rd_fin = 1; sdram_wr_fin = 1; sdram_rd_data = 32'h77;
        tick();
        tick();
        sdram_rd_fin = 0; sdram_wr_fin = 0;
        chk("s_fins",  32'({if_fin, mem_fin}), 32'd0);
        chk("s_busy",  32'(busy), 32'd0);
        chk("s_rdata", mem_rdata, 32'd0);
        chk("s_reqs",  32'({sdram_rd_req, sdram_wr_req}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
